mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 34 +++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared pipeline constants for EX/M, MEM and WB
package mem_stage_pkg;

  localparam int CTRL_REG_WRITE = 8;
  localparam int CTRL_WB_SEL_HI = 7;
  localparam int CTRL_WB_SEL_LO = 6;
  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_SIZE_HI   = 3;
  localparam int CTRL_SIZE_LO   = 2;
  localparam int CTRL_UNSIGNED  = 1;
  localparam int CTRL_HALT      = 0;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC8 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } ld_ctrl_t;

  // Encoding 2'b10 decodes as a word access, so size[1] alone marks "word".
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SIZE_HALF) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-lane store steering and load extraction/extension
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  input  ld_ctrl_t    ld_ctrl_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be_o   = 4'hF;
    st_data_o = st_data_i;
    if (st_size_i == SIZE_BYTE) begin
      st_be_o   = 4'b0001 << st_off_i;
      st_data_o = {4{st_data_i[7:0]}};
    end else if (st_size_i == SIZE_HALF) begin
      st_be_o   = st_off_i[1] ? 4'b1100 : 4'b0011;
      st_data_o = {2{st_data_i[15:0]}};
    end
  end

  always_comb begin
    ld_byte   = ld_word_i[{ld_ctrl_i.off, 3'b000} +: 8];
    ld_half   = ld_ctrl_i.off[1] ? ld_word_i[31:16] : ld_word_i[15:0];
    ld_data_o = '0;
    if (ld_ctrl_i.valid) begin
      if (ld_ctrl_i.size == SIZE_BYTE) begin
        ld_data_o = {{24{~ld_ctrl_i.uns & ld_byte[7]}}, ld_byte};
      end else if (ld_ctrl_i.size == SIZE_HALF) begin
        ld_data_o = {{16{~ld_ctrl_i.uns & ld_half[15]}}, ld_half};
      end else begin
        ld_data_o = ld_word_i;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: data memory, alignment, MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_REG    = 32,
  parameter int NB_CTRL   = 9,
  parameter int NB_ADDR   = 5,
  parameter int MEM_WORDS = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dunit_clk_en,
  input  logic [NB_REG-1:0]  i_pc_eight,
  input  logic [NB_REG-1:0]  i_alu_result,
  input  logic [NB_REG-1:0]  i_w_data,
  input  logic [NB_ADDR-1:0] i_data_addr,
  input  logic [NB_CTRL-1:0] i_control,
  input  logic [7:0]         i_dunit_mem_addr,
  output logic [NB_REG-1:0]  o_dunit_mem_data,
  output logic [NB_REG-1:0]  o_read_data,
  output logic [NB_REG-1:0]  o_alu_result,
  output logic [NB_REG-1:0]  o_pc_eight,
  output logic [NB_ADDR-1:0] o_data_addr,
  output logic [3:0]         o_control,
  output logic               o_misaligned
);

  localparam int MEM_AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic [1:0]        acc_size;
  logic [1:0]        acc_off;
  logic              acc_read;
  logic              acc_write;
  logic              acc_mis;
  logic              mem_we;
  logic [MEM_AW-1:0] word_idx;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  logic [NB_REG-1:0]  alu_d, alu_q;
  logic [NB_REG-1:0]  pc8_d, pc8_q;
  logic [NB_ADDR-1:0] dst_d, dst_q;
  logic [3:0]         ctrl_d, ctrl_q;
  logic               mis_d, mis_q;
  ld_ctrl_t           ld_ctrl_d, ld_ctrl_q;
  logic [31:0]        rdata_q;
  logic [31:0]        dunit_raw_q;
  logic               dunit_vld_q;

  assign acc_size  = i_control[CTRL_SIZE_HI:CTRL_SIZE_LO];
  assign acc_off   = i_alu_result[1:0];
  assign acc_read  = i_control[CTRL_MEM_READ];
  assign acc_write = i_control[CTRL_MEM_WRITE];
  assign acc_mis   = is_misaligned(acc_size, acc_off);
  assign word_idx  = i_alu_result[MEM_AW+1:2];
  // A store coinciding with reset must not land, even though the array itself is never reset.
  assign mem_we    = i_dunit_clk_en & acc_write & ~acc_mis & ~i_reset;

  mem_align u_align (
    .st_size_i (acc_size),
    .st_off_i  (acc_off),
    .st_data_i (i_w_data[31:0]),
    .st_be_o   (st_be),
    .st_data_o (st_data),
    .ld_ctrl_i (ld_ctrl_q),
    .ld_word_i (rdata_q),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
    if (i_dunit_clk_en) rdata_q <= mem[word_idx];
  end

  always_ff @(posedge i_clk) begin
    dunit_raw_q <= mem[i_dunit_mem_addr[MEM_AW-1:0]];
  end

  always_comb begin
    alu_d     = alu_q;
    pc8_d     = pc8_q;
    dst_d     = dst_q;
    ctrl_d    = ctrl_q;
    mis_d     = mis_q;
    ld_ctrl_d = ld_ctrl_q;
    if (i_dunit_clk_en) begin
      alu_d           = i_alu_result;
      pc8_d           = i_pc_eight;
      dst_d           = i_data_addr;
      ctrl_d          = {i_control[CTRL_REG_WRITE], i_control[CTRL_WB_SEL_HI:CTRL_WB_SEL_LO],
                         i_control[CTRL_HALT]};
      mis_d           = (acc_read | acc_write) & acc_mis;
      ld_ctrl_d.valid = acc_read & ~acc_mis;
      ld_ctrl_d.size  = acc_size;
      ld_ctrl_d.uns   = i_control[CTRL_UNSIGNED];
      ld_ctrl_d.off   = acc_off;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      alu_q       <= '0;
      pc8_q       <= '0;
      dst_q       <= '0;
      ctrl_q      <= '0;
      mis_q       <= 1'b0;
      ld_ctrl_q   <= '0;
      dunit_vld_q <= 1'b0;
    end else begin
      alu_q       <= alu_d;
      pc8_q       <= pc8_d;
      dst_q       <= dst_d;
      ctrl_q      <= ctrl_d;
      mis_q       <= mis_d;
      ld_ctrl_q   <= ld_ctrl_d;
      dunit_vld_q <= 1'b1;
    end
  end

  assign o_read_data      = NB_REG'(ld_data);
  assign o_dunit_mem_data = dunit_vld_q ? NB_REG'(dunit_raw_q) : '0;
  assign o_alu_result     = alu_q;
  assign o_pc_eight       = pc8_q;
  assign o_data_addr      = dst_q;
  assign o_control        = ctrl_q;
  assign o_misaligned     = mis_q;

endmodule
